// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STREAK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IBUSY,
    ARB_DBUSY
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

endpackage

// File: rtl/mem_arb_streak.sv
// Grant decision between the fetch and memory ports plus the saturating
// count of data grants taken while an instruction request is pending.
module mem_arb_streak
  import mem_arb_pkg::*;
#(
  parameter int unsigned STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic      CLK,
  input  logic      Reset,
  input  logic      i_elig,
  input  logic      d_elig,
  input  logic      i_req,
  output arb_port_t grant_port,
  output logic      grant_valid
);

  localparam int unsigned CW = $clog2(STREAK_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STREAK_MAX);

  logic [CW-1:0] streak;

  // Data wins ties until it has starved the fetch port STREAK_MAX times.
  always_comb begin
    grant_valid = i_elig | d_elig;
    grant_port  = PORT_I;
    if (d_elig && (!i_elig || streak != SMAX)) begin
      grant_port = PORT_D;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      streak <= '0;
    end else if (grant_valid) begin
      if (grant_port == PORT_D && i_req) begin
        if (streak != SMAX) begin
          streak <= streak + 1'b1;
        end
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch (I) and memory-stage (D)
// ports: serializes requests, runs the memory handshake, pulses Valid.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IReqF,
  input  logic [ADDR_W-1:0] IAddrF,
  output logic [DATA_W-1:0] IRdataF,
  output logic              IValidF,
  input  logic              DReqM,
  input  logic              DWeM,
  input  logic [ADDR_W-1:0] DAddrM,
  input  logic [DATA_W-1:0] DWdataM,
  output logic [DATA_W-1:0] DRdataM,
  output logic              DValidM,
  output logic              StallMemF,
  output logic              StallMemM,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  input  logic              MemAck
);

  arb_state_t state;
  arb_port_t  grant_port;
  logic       grant_valid;
  logic       i_elig;
  logic       d_elig;

  // A port in its Valid cycle still holds Req; masking it avoids a regrant.
  assign i_elig = (state == ARB_IDLE) && IReqF && !IValidF;
  assign d_elig = (state == ARB_IDLE) && DReqM && !DValidM;

  assign StallMemF = IReqF & ~IValidF;
  assign StallMemM = DReqM & ~DValidM;

  mem_arb_streak #(
    .STREAK_MAX(STREAK_MAX)
  ) u_streak (
    .CLK        (CLK),
    .Reset      (Reset),
    .i_elig     (i_elig),
    .d_elig     (d_elig),
    .i_req      (IReqF),
    .grant_port (grant_port),
    .grant_valid(grant_valid)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= ARB_IDLE;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
      IRdataF  <= '0;
      DRdataM  <= '0;
      IValidF  <= 1'b0;
      DValidM  <= 1'b0;
    end else begin
      IValidF <= 1'b0;
      DValidM <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            MemReq <= 1'b1;
            if (grant_port == PORT_D) begin
              MemWe    <= DWeM;
              MemAddr  <= DAddrM;
              MemWdata <= DWdataM;
              state    <= ARB_DBUSY;
            end else begin
              MemWe   <= 1'b0;
              MemAddr <= IAddrF;
              state   <= ARB_IBUSY;
            end
          end
        end
        ARB_IBUSY: begin
          if (MemAck) begin
            MemReq  <= 1'b0;
            IRdataF <= MemRdata;
            IValidF <= 1'b1;
            state   <= ARB_IDLE;
          end
        end
        ARB_DBUSY: begin
          if (MemAck) begin
            MemReq <= 1'b0;
            if (!MemWe) begin
              DRdataM <= MemRdata;
            end
            DValidM <= 1'b1;
            state   <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// reference model; the bench plays both requesters and the memory.
module tb_mem_arbiter;

  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        IReqF = 1'b0;
  logic [31:0] IAddrF = '0;
  logic [31:0] IRdataF;
  logic        IValidF;
  logic        DReqM = 1'b0;
  logic        DWeM = 1'b0;
  logic [31:0] DAddrM = '0;
  logic [31:0] DWdataM = '0;
  logic [31:0] DRdataM;
  logic        DValidM;
  logic        StallMemF;
  logic        StallMemM;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata = '0;
  logic        MemAck = 1'b0;

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STREAK_MAX(SMAX)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .IReqF    (IReqF),
    .IAddrF   (IAddrF),
    .IRdataF  (IRdataF),
    .IValidF  (IValidF),
    .DReqM    (DReqM),
    .DWeM     (DWeM),
    .DAddrM   (DAddrM),
    .DWdataM  (DWdataM),
    .DRdataM  (DRdataM),
    .DValidM  (DValidM),
    .StallMemF(StallMemF),
    .StallMemM(StallMemM),
    .MemReq   (MemReq),
    .MemWe    (MemWe),
    .MemAddr  (MemAddr),
    .MemWdata (MemWdata),
    .MemRdata (MemRdata),
    .MemAck   (MemAck)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // memory model
  logic [31:0] mem_model [bit [31:0]];
  int          lat_q [$];
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  int          mem_last_lat = 0;
  int          rise_cyc = 0;
  bit          force_ack = 0;

  // requesters
  logic [31:0] i_q [$];
  dreq_t       d_q [$];
  int          i_left = 0, d_left = 0, i_prob = 100, d_prob = 100;
  bit          i_drop = 0, d_drop = 0;
  int          i_done = 0, d_done = 0, d_valid_cyc = 0;

  // reference model
  int          m_owner = 0;  // 0 none, 1 instruction, 2 data
  int          m_streak = 0;
  logic        m_req = 0, m_we = 0, m_iv = 0, m_dv = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_ird = '0, m_drd = '0;
  int          grants [$];
  int          grant_at [$];
  int          i_wait_d = 0, max_wait = 0;
  int          mreq_rises = 0;
  logic        prev_mreq = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] rand_addr();
    return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the reference model across the coming clock edge.
  task automatic predict();
    logic ei, ed, niv, ndv;
    if (Reset) begin
      m_owner = 0; m_streak = 0; m_req = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
      m_iv = 0; m_dv = 0; i_wait_d = 0;
      return;
    end
    ei = IReqF && !m_iv;
    ed = DReqM && !m_dv;
    niv = 0; ndv = 0;
    if (m_owner == 0) begin
      if (ed && !(ei && m_streak == SMAX)) begin
        if (ei) i_wait_d++;
        m_streak = IReqF ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
        m_owner = 2; m_req = 1; m_we = DWeM; m_addr = DAddrM; m_wdata = DWdataM;
        grants.push_back(2); grant_at.push_back(cyc + 1);
      end else if (ei) begin
        m_streak = 0; i_wait_d = 0;
        m_owner = 1; m_req = 1; m_we = 0; m_addr = IAddrF;
        grants.push_back(1); grant_at.push_back(cyc + 1);
      end
    end else if (MemAck) begin
      if (m_owner == 1) begin
        m_ird = MemRdata; niv = 1;
      end else begin
        if (!m_we) m_drd = MemRdata;
        ndv = 1;
      end
      m_owner = 0; m_req = 0;
    end
    m_iv = niv; m_dv = ndv;
    if (i_wait_d > max_wait) max_wait = i_wait_d;
  endtask

  task automatic check_outputs();
    chk("MemReq", 32'(MemReq), 32'(m_req));
    chk("MemWe", 32'(MemWe), 32'(m_we));
    chk("MemAddr", MemAddr, m_addr);
    if (m_req && m_we) chk("MemWdata", MemWdata, m_wdata);
    chk("IValidF", 32'(IValidF), 32'(m_iv));
    chk("DValidM", 32'(DValidM), 32'(m_dv));
    chk("IRdataF", IRdataF, m_ird);
    chk("DRdataM", DRdataM, m_drd);
    if (MemReq === 1'b1 && prev_mreq === 1'b0) mreq_rises++;
    prev_mreq = MemReq;
  endtask

  // Bench-side behaviour of the memory and both requesters for this cycle.
  task automatic react();
    dreq_t d;
    MemAck = 0;
    MemRdata = $urandom;
    if (!MemReq) mem_busy = 0;
    if (force_ack) begin
      MemAck = 1; force_ack = 0;
    end else if (MemReq) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_cnt = (lat_q.size() > 0) ? lat_q.pop_front()
                : (($urandom_range(0, 9) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 3));
        mem_last_lat = mem_cnt;
        rise_cyc = cyc;
      end else begin
        mem_cnt--;
      end
      if (mem_cnt == 0) begin
        MemAck = 1; mem_busy = 0;
        if (MemWe) mem_model[MemAddr] = MemWdata;
        else MemRdata = rd(MemAddr);
      end
    end

    if (IValidF) begin
      i_done++; i_drop = 1;
      chk("i_rdata", IRdataF, rd(IAddrF));
      chk("i_valid_lat", 32'(cyc - rise_cyc), 32'(mem_last_lat + 1));
    end else begin
      if (i_drop) begin IReqF = 0; i_drop = 0; end
      if (!IReqF && i_left > 0 && $urandom_range(0, 99) < i_prob) begin
        IReqF = 1; i_left--;
        IAddrF = (i_q.size() > 0) ? i_q.pop_front() : rand_addr();
      end
    end

    if (DValidM) begin
      d_done++; d_drop = 1; d_valid_cyc = cyc;
      if (!DWeM) chk("d_rdata", DRdataM, rd(DAddrM));
      chk("d_valid_lat", 32'(cyc - rise_cyc), 32'(mem_last_lat + 1));
    end else begin
      if (d_drop) begin DReqM = 0; d_drop = 0; end
      if (!DReqM && d_left > 0 && $urandom_range(0, 99) < d_prob) begin
        if (d_q.size() > 0) d = d_q.pop_front();
        else begin d.we = 1'($urandom_range(0, 1)); d.addr = rand_addr(); d.wdata = $urandom; end
        DReqM = 1; DWeM = d.we; DAddrM = d.addr; DWdataM = d.wdata; d_left--;
      end
    end
  endtask

  task automatic step();
    predict();
    @(posedge CLK);
    #1;
    cyc++;
    check_outputs();
    react();
    #1;
    chk("StallMemF", 32'(StallMemF), 32'(IReqF & ~m_iv));
    chk("StallMemM", 32'(StallMemM), 32'(DReqM & ~m_dv));
  endtask

  task automatic run_until(input int ni, input int nd, input int budget, input string tag);
    int n = 0;
    while ((i_done < ni || d_done < nd) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(i_done >= ni && d_done >= nd), 32'd1);
  endtask

  task automatic apply_reset();
    Reset = 1; IReqF = 0; DReqM = 0; i_drop = 0; d_drop = 0;
    step();
    Reset = 0;
  endtask

  initial begin
    int g0, r0, n, t;
    logic [31:0] drd_before;

    repeat (3) step();
    Reset = 0;
    chk("rst_MemReq", 32'(MemReq), 32'd0);
    chk("rst_MemAddr", MemAddr, 32'd0);
    chk("rst_MemWdata", MemWdata, 32'd0);
    chk("rst_IRdataF", IRdataF, 32'd0);
    chk("rst_DRdataM", DRdataM, 32'd0);

    // single instruction read, memory answers 2 cycles after MemReq
    mem_model[32'h100] = 32'hE3A0_0001;
    i_q.push_back(32'h100); lat_q.push_back(2);
    i_left = 1; d_left = 0;
    t = i_done;
    run_until(t + 1, d_done, 40, "single_i");
    chk("single_i_data", IRdataF, 32'hE3A0_0001);
    repeat (3) step();

    // contention: data write first, instruction right after DValidM
    i_q.push_back(32'h104);
    d_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hDEAD_BEEF});
    drd_before = DRdataM;
    g0 = grants.size();
    i_left = 1; d_left = 1;
    run_until(i_done + 1, d_done + 1, 60, "contention");
    chk("cont_first_port", 32'(grants[g0]), 32'd2);
    chk("cont_second_port", 32'(grants[g0 + 1]), 32'd1);
    chk("cont_i_grant_cycle", 32'(grant_at[g0 + 1] - d_valid_cyc), 32'd1);
    chk("cont_drdata_hold", DRdataM, drd_before);
    chk("cont_mem_written", rd(32'h200), 32'hDEAD_BEEF);
    repeat (3) step();

    // both ports held busy: the fetch port must never wait beyond the limit
    i_left = 6; d_left = 6;
    run_until(i_done + 6, d_done + 6, 300, "held");
    chk("held_max_overtake", 32'(max_wait <= SMAX), 32'd1);
    repeat (3) step();

    // Req still high in the IValidF cycle must not cause a second access
    r0 = mreq_rises;
    i_left = 1;
    run_until(i_done + 1, d_done, 40, "noregrant");
    repeat (5) step();
    chk("noregrant_pulses", 32'(mreq_rises - r0), 32'd1);

    // reset while the data access is outstanding, then a stale MemAck
    d_q.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'h1234_5678});
    lat_q.push_back(10);
    d_left = 1;
    t = d_done;
    n = 0;
    while (MemReq !== 1'b1 && n < 20) begin step(); n++; end
    chk("rst_mid_granted", 32'(MemReq), 32'd1);
    repeat (3) step();
    d_left = 0;
    force_ack = 1;
    apply_reset();
    repeat (6) step();
    chk("rst_mid_no_valid", 32'(d_done - t), 32'd0);
    chk("rst_mid_no_write", 32'(mem_model.exists(32'h300)), 32'd0);
    chk("rst_mid_MemReq", 32'(MemReq), 32'd0);

    // variable memory latency
    lat_q.push_back(1); lat_q.push_back(5); lat_q.push_back(10);
    i_q.push_back(32'h40); i_q.push_back(32'h44); i_q.push_back(32'h48);
    i_left = 3;
    run_until(i_done + 3, d_done, 80, "varlat");
    repeat (3) step();

    // randomized traffic with occasional resets
    for (int k = 0; k < 4000; k++) begin
      if (k % 200 == 0) begin
        i_prob = $urandom_range(5, 100); d_prob = $urandom_range(5, 100);
        i_left = 1000; d_left = 1000;
      end
      if ($urandom_range(0, 399) == 0) apply_reset();
      else step();
    end
    i_left = 0; d_left = 0;
    n = 0;
    while ((IReqF || DReqM) && n < 200) begin step(); n++; end
    chk("drain_timeout", 32'(IReqF || DReqM), 32'd0);
    chk("final_max_overtake", 32'(max_wait <= SMAX), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
